// File: rtl/sram_two_port_arbiter.sv
// sram_two_port_arbiter
//   Shares one asynchronous 16-bit SRAM between two requesters (port 0 and
//   port 1). Each access is IDLE (grant + ack) -> ACCESS for ACCESS_CYCLES
//   clocks -> DONE (bus turnaround, read-valid pulse) -> IDLE.
//
//   Optional feature: define SRAM_ARB_ROUND_ROBIN_EN to alternate grants on
//   simultaneous requests. Left undefined, port 0 always wins a tie.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   pN_req/we/addr/   request and command from requester N. The command is
//   wdata/be          held stable while req = 1 until pN_ack.
//   pN_ack            one-cycle pulse in the IDLE cycle that grants port N
//   pN_rdata/rvalid   read data and its one-cycle valid pulse
//   SRAM_*            registered board-pin outputs; SRAM_DQ is tri-stated
//                     unless a write is in ACCESS
//   dbg_state         current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//
// Handshake: a request is a level on pN_req. It is consumed only in the
// cycle where pN_ack = 1. A request dropped before that cycle is forgotten.
module sram_two_port_arbiter #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_be,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_be,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              gnt_q;      // port owning the access in flight
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              dq_oe;

    logic              any_req;
    logic              gnt_sel;
    logic              start;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_be;

    assign any_req = p0_req | p1_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // last_q = port granted most recently; on a tie the other port wins.
    logic last_q;
    assign gnt_sel = p1_req & (~p0_req | ~last_q);
`else
    assign gnt_sel = p1_req & ~p0_req;
`endif

    // The ack is issued in the granting IDLE cycle itself, so it has to be
    // combinational. It is gated by reset so no grant is seen during reset.
    assign start  = (state == IDLE) & any_req & ~reset;
    assign p0_ack = start & ~gnt_sel;
    assign p1_ack = start &  gnt_sel;

    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        sel_be    = p0_be;
        if (gnt_sel) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
            sel_be    = p1_be;
        end
    end

    assign SRAM_DQ   = dq_oe ? wdata_q : {DATA_W{1'bz}};
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            dq_oe     <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        // Pin values for the first ACCESS cycle are loaded here
                        // so the SRAM sees them on a register output.
                        gnt_q     <= gnt_sel;
                        we_q      <= sel_we;
                        wdata_q   <= sel_wdata;
                        dq_oe     <= sel_we;
                        SRAM_ADDR <= sel_addr;
                        SRAM_CE_N <= 1'b0;
                        SRAM_OE_N <= sel_we;
                        SRAM_WE_N <= ~sel_we;
                        SRAM_UB_N <= ~sel_be[1];
                        SRAM_LB_N <= ~sel_be[0];
                        cnt       <= '0;
                        state     <= ACCESS;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                        last_q    <= gnt_sel;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        // Read data is sampled on the edge that ends the access.
                        if (!we_q) begin
                            if (gnt_q) begin
                                p1_rdata  <= SRAM_DQ;
                                p1_rvalid <= 1'b1;
                            end else begin
                                p0_rdata  <= SRAM_DQ;
                                p0_rvalid <= 1'b1;
                            end
                        end
                        dq_oe     <= 1'b0;
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        SRAM_UB_N <= 1'b1;
                        SRAM_LB_N <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                        // WE_N rises for the final cycle, and DQ is still driven,
                        // so write data is held past the rising edge.
                        if (cnt + 4'd1 == LAST_CNT) begin
                            SRAM_WE_N <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_two_port_arbiter.sv
// Directed bench for sram_two_port_arbiter. Instance u_dut uses
// ACCESS_CYCLES = 2 and a small behavioural SRAM. Instance u_dut4 uses
// ACCESS_CYCLES = 4 with a fixed read pattern on its data bus.
module tb_sram_two_port_arbiter;

    localparam int AC_A = 2;
    localparam int AC_B = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [17:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic [1:0]  p0_be, p1_be;
    logic        p0_ack, p0_rvalid, p1_ack, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;
    logic [1:0]  a_state;

    sram_two_port_arbiter #(.ADDR_W(18), .DATA_W(16), .ACCESS_CYCLES(AC_A)) u_dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .dbg_state(a_state)
    );

    // Behavioural SRAM: lanes written on each clock with CE_N and WE_N low,
    // read data driven while CE_N and OE_N are low with WE_N high.
    logic [15:0] mem [0:1023];
    logic        model_en;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic ub, input logic lb);
        logic [15:0] r;
        r = old;
        if (!ub) r[15:8] = d[15:8];
        if (!lb) r[7:0]  = d[7:0];
        return r;
    endfunction

    assign model_en = !ce_n && !oe_n && we_n;
    assign sram_dq  = model_en ? mem[sram_addr[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            mem[sram_addr[9:0]] <= merge(mem[sram_addr[9:0]], sram_dq, ub_n, lb_n);
        end
    end

    // ---------------- instance B (ACCESS_CYCLES = 4) ----------------
    logic        b_req, b_we, b_nreq, b_nwe;
    logic [17:0] b_addr, b_naddr;
    logic [15:0] b_wdata, b_nwdata;
    logic [1:0]  b_be, b_nbe;
    logic        b_ack, b_rvalid, b_nack, b_nrvalid;
    logic [15:0] b_rdata, b_nrdata;
    logic [17:0] b_sram_addr;
    wire  [15:0] b_dq;
    logic        b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;
    logic [1:0]  b_state;

    sram_two_port_arbiter #(.ADDR_W(18), .DATA_W(16), .ACCESS_CYCLES(AC_B)) u_dut4 (
        .clk(clk), .reset(reset),
        .p0_req(b_req), .p0_we(b_we), .p0_addr(b_addr), .p0_wdata(b_wdata), .p0_be(b_be),
        .p0_ack(b_ack), .p0_rdata(b_rdata), .p0_rvalid(b_rvalid),
        .p1_req(b_nreq), .p1_we(b_nwe), .p1_addr(b_naddr), .p1_wdata(b_nwdata), .p1_be(b_nbe),
        .p1_ack(b_nack), .p1_rdata(b_nrdata), .p1_rvalid(b_nrvalid),
        .SRAM_ADDR(b_sram_addr), .SRAM_DQ(b_dq),
        .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n), .SRAM_WE_N(b_we_n),
        .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n), .dbg_state(b_state)
    );

    assign b_dq = (!b_ce_n && !b_oe_n) ? 16'h5A5A : 16'hzzzz;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access on instance A with cycle-by-cycle pin checks.
    // Cycle 0 = ack cycle, cycles 1..AC_A = ACCESS, cycle AC_A+1 = DONE.
    task automatic access_a(input bit port, input logic we, input logic [17:0] addr,
                            input logic [15:0] wdata, input logic [1:0] be,
                            input logic [15:0] exp_rd);
        int          waited;
        logic [1:0]  nbe;
        logic [4:0]  pins;
        nbe = ~be;
        @(posedge clk); #1;
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be;
        end
        waited = 0;
        @(negedge clk);
        while (!(port ? p1_ack : p0_ack) && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check("ack_wait", 32'(waited < 20), 32'd1);
        check("ack_other", 32'(port ? p0_ack : p1_ack), 32'd0);
        @(posedge clk); #1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        for (int c = 1; c <= AC_A + 1; c++) begin
            @(negedge clk);
            if (c <= AC_A) begin
                check("ce_n", 32'(ce_n), 32'd0);
                check("oe_n", 32'(oe_n), 32'(we));
                check("we_n", 32'(we_n), (we && c < AC_A) ? 32'd0 : 32'd1);
                check("lanes", 32'({ub_n, lb_n}), 32'(nbe));
                check("addr", 32'(sram_addr), 32'(addr));
                if (we) check("dq_drive", 32'(sram_dq), 32'(wdata));
                check("rvalid_early", 32'(port ? p1_rvalid : p0_rvalid), 32'd0);
            end else begin
                pins = {ce_n, oe_n, we_n, ub_n, lb_n};
                check("pins_done", 32'(pins), 32'h1f);
                check("rvalid", 32'(port ? p1_rvalid : p0_rvalid), 32'(!we));
                if (!we) check("rdata", 32'(port ? p1_rdata : p0_rdata), 32'(exp_rd));
                else     check("dq_released", 32'(sram_dq !== wdata), 32'd1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int gseq[$];
        int waited;
        int ce_low;
        int lat;
        int p1_acks;

        reset = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0;
        b_nreq = 0; b_nwe = 0; b_naddr = 0; b_nwdata = 0; b_nbe = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_pins", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1f);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_acks", 32'({p0_ack, p1_ack}), 32'd0);
        check("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
        check("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'd0);
        check("rst_state", 32'(a_state), 32'd0);
        check("rst_b_pins", 32'({b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n}), 32'h1f);

        // write then read on port 1
        access_a(1'b1, 1'b1, 18'h00123, 16'hBEEF, 2'b11, 16'h0000);
        access_a(1'b1, 1'b0, 18'h00123, 16'h0000, 2'b11, 16'hBEEF);

        // byte lanes on port 0: upper lane only
        access_a(1'b0, 1'b1, 18'h00200, 16'hA5C3, 2'b11, 16'h0000);
        access_a(1'b0, 1'b1, 18'h00200, 16'h1234, 2'b10, 16'h0000);
        access_a(1'b0, 1'b0, 18'h00200, 16'h0000, 2'b11, 16'h12C3);

        // be = 00 runs the full cycle but changes nothing
        access_a(1'b1, 1'b1, 18'h00300, 16'h1111, 2'b11, 16'h0000);
        access_a(1'b1, 1'b1, 18'h00300, 16'hFFFF, 2'b00, 16'h0000);
        access_a(1'b1, 1'b0, 18'h00300, 16'h0000, 2'b11, 16'h1111);

        // contention: both ports read continuously for 40 cycles
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 18'h00123; p0_be = 2'b11;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 18'h00200; p1_be = 2'b11;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (p0_ack && p1_ack) check("double_ack", 32'd1, 32'd0);
            if (p0_ack) gseq.push_back(0);
            if (p1_ack) gseq.push_back(1);
            if (c < 39) begin
                @(posedge clk); #1;
            end
        end
        check("grant_count", 32'(gseq.size()), 32'd10);
        for (int i = 0; i < 4 && i < gseq.size(); i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            check("grant_order", 32'(gseq[i]), 32'(i % 2));
`else
            check("grant_order", 32'(gseq[i]), 32'd0);
`endif
        end
        // drop p0: p1 must now be served
        @(posedge clk); #1;
        p0_req = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!p1_ack && waited < 10) begin
            waited++;
            @(negedge clk);
        end
        check("p1_after_drop", 32'(waited < 10), 32'd1);
        @(posedge clk); #1;
        p1_req = 1'b0;
        repeat (6) @(negedge clk);
        check("p0_rdata_hold", 32'(p0_rdata), 32'hBEEF);
        check("p1_rdata_hold", 32'(p1_rdata), 32'h12C3);

        // request dropped before ack is never served
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 18'h00123;
        @(negedge clk);
        check("drop_p0_ack", 32'(p0_ack), 32'd1);
        @(posedge clk); #1;
        p0_req = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 18'h00200;
        @(posedge clk); #1;
        p1_req = 1'b0;
        p1_acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (p1_ack) p1_acks++;
        end
        check("dropped_req", 32'(p1_acks), 32'd0);

        // reset during the first ACCESS cycle of a write
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 18'h000AB; p0_wdata = 16'h7777; p0_be = 2'b11;
        @(negedge clk);
        check("rst_mid_ack", 32'(p0_ack), 32'd1);
        @(posedge clk); #1;
        p0_req = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        check("rst_mid_ce", 32'(ce_n), 32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 18'h00123; p1_be = 2'b11;
        @(negedge clk);
        check("rst_mid_pins", 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'h1f);
        check("rst_mid_dq", 32'(sram_dq !== 16'h7777), 32'd1);
        check("rst_mid_rvalid", 32'(p0_rvalid), 32'd0);
        check("rst_fresh_ack", 32'(p1_ack), 32'd1);
        @(posedge clk); #1;
        p1_req = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        check("rst_fresh_rvalid", 32'(p1_rvalid), 32'd1);
        check("rst_fresh_rdata", 32'(p1_rdata), 32'hBEEF);

        // ACCESS_CYCLES = 4: rvalid 5 cycles after ack, CE_N low 4 cycles
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 18'h00005; b_be = 2'b11;
        waited = 0;
        @(negedge clk);
        while (!b_ack && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check("b_ack_wait", 32'(waited < 20), 32'd1);
        @(posedge clk); #1;
        b_req = 1'b0;
        ce_low = 0;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (!b_ce_n) ce_low++;
            if (b_rvalid && lat == 0) lat = c;
        end
        check("b_latency", 32'(lat), 32'd5);
        check("b_ce_cycles", 32'(ce_low), 32'd4);
        check("b_rdata", 32'(b_rdata), 32'h5A5A);
        check("b_other_ack", 32'(b_nack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
